// File: rtl/mips_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Stream framing: big-endian word-count header, then 4 bytes per word.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Defaults shared with the instruction memory sizing (fetch index pc[9:2]).
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_TIMEOUT = 1000000;

  // States in which the loader takes bytes from the source.
  function automatic logic is_accepting(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs big-endian bytes into 32-bit words; first byte lands in [31:24].
// Latency: word_vld/word_dat registered on the 4th byte's edge, valid the following cycle.
// Backpressure: none; consumes a byte on every byte_vld cycle.
//
// Ports: clk/reset_n (sync, active-low); clear restarts the byte count;
// byte_vld/byte_dat accepted byte; last_byte high when the next byte completes a word;
// word_vld single-cycle strobe with word_dat holding the completed word.
module word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        last_byte,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int SH_W  = 8 * (BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt;
  logic [SH_W-1:0]  shift_dat;

  assign last_byte = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt  <= '0;
      shift_dat <= '0;
      word_vld  <= 1'b0;
      word_dat  <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        byte_cnt  <= '0;
        shift_dat <= '0;
      end else if (byte_vld) begin
        if (last_byte) begin
          // Completing byte goes straight into the output word, so the write
          // strobe follows the handshake by exactly one cycle with no bubble.
          word_dat <= {shift_dat, byte_dat};
          word_vld <= 1'b1;
          byte_cnt <= '0;
        end else begin
          shift_dat <= {shift_dat[SH_W-9:0], byte_dat};
          byte_cnt  <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a length/data/checksum byte stream, holds core in reset until verified.
// Latency: imem_we one cycle after each word's last byte; done/cpu_reset_n one cycle after the checksum byte.
// Backpressure: byte_ready only in header/data/checksum states; one byte per cycle sustained, no write bubbles.
//
// Ports: clk, reset_n (sync, active-low); load_start pulse begins a session;
// byte_valid/byte_data/byte_ready source handshake; imem_we/imem_addr/imem_wdata memory write port;
// cpu_reset_n core reset (high only in RUN); done (RUN) and error (ERR) status levels.
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              done,
  output logic              error
);

  localparam int LEN_W = HDR_BYTES * 8;

  state_t           state;
  state_t           state_nxt;
  logic             hs;
  logic             start;
  logic             data_hs;
  logic             last_byte;
  logic             tmo_hit;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len_rx;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] word_cnt;
  logic [7:0]       csum_acc;
  logic [31:0]      tmo_cnt;

  assign hs      = byte_valid && byte_ready;
  assign data_hs = hs && (state == ST_DATA);
  assign start   = load_start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
  assign len_rx  = {len_hi, byte_data};

  // Fires on the TIMEOUT-th consecutive cycle without a handshake.
  assign tmo_hit = (TIMEOUT != 0) && is_accepting(state) && !hs &&
                   (tmo_cnt == TIMEOUT - 1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: if (load_start) state_nxt = ST_LEN_HI;
      ST_LEN_HI: if (hs) state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (hs) begin
          if ((len_rx == '0) || (32'(len_rx) > DEPTH)) state_nxt = ST_ERR;
          else                                         state_nxt = ST_DATA;
        end
      end
      ST_DATA: if (hs && last_byte && (word_cnt == last_idx)) state_nxt = ST_CSUM;
      ST_CSUM: begin
        if (hs) state_nxt = (byte_data == csum_acc) ? ST_RUN : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (tmo_hit) state_nxt = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      byte_ready  <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_reset_n <= 1'b0;
      len_hi      <= '0;
      last_idx    <= '0;
      word_cnt    <= '0;
      imem_addr   <= '0;
      csum_acc    <= '0;
      tmo_cnt     <= '0;
    end else begin
      // Status outputs are decoded from the next state so they stay registered
      // yet change on the same edge as the state itself.
      state       <= state_nxt;
      byte_ready  <= is_accepting(state_nxt);
      done        <= (state_nxt == ST_RUN);
      error       <= (state_nxt == ST_ERR);
      cpu_reset_n <= (state_nxt == ST_RUN);

      if (start) begin
        len_hi    <= '0;
        last_idx  <= '0;
        word_cnt  <= '0;
        imem_addr <= '0;
        csum_acc  <= '0;
        tmo_cnt   <= '0;
      end else begin
        if (hs) begin
          // The checksum byte itself also folds in here; harmless, the session ends on it.
          csum_acc <= csum_acc ^ byte_data;
          tmo_cnt  <= '0;
        end else if (is_accepting(state) && (TIMEOUT != 0)) begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end

        if (hs && (state == ST_LEN_HI)) len_hi <= byte_data;
        // Only consumed when the length passed the range check, so N>=1 here.
        if (hs && (state == ST_LEN_LO)) last_idx <= len_rx - LEN_W'(1);

        if (data_hs && last_byte) begin
          imem_addr <= word_cnt[ADDR_W-1:0];
          word_cnt  <= word_cnt + LEN_W'(1);
        end
      end
    end
  end

  word_packer u_word_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start),
    .byte_vld  (data_hs),
    .byte_dat  (byte_data),
    .last_byte (last_byte),
    .word_vld  (imem_we),
    .word_dat  (imem_wdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_n;
  logic              done;
  logic              error;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_start  (load_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  // Write-port monitor: one entry per cycle with the strobe high.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) wr_q.push_back('{int'(imem_addr), imem_wdata});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference stream builder: header N (big-endian), words big-endian, XOR checksum.
  task automatic build_stream(input logic [31:0] w[$], input bit corrupt, output logic [7:0] s[$]);
    logic [15:0] n;
    logic [7:0]  x;
    s = {};
    n = 16'(w.size());
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[i]) for (int k = 3; k >= 0; k--) s.push_back(w[i][8*k +: 8]);
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    if (corrupt) x = x ^ 8'h01;
    s.push_back(x);
  endtask

  // Called just after a falling edge; returns just after the falling edge following the handshake.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int waitc = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    ok = (byte_ready === 1'b1);
    if (ok) @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int max_gap, output int sent);
    bit ok;
    sent = 0;
    foreach (s[i]) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      send_byte(s[i], ok);
      if (!ok) break;
      sent++;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // Stray byte_valid in IDLE must not be taken.
    byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b0)     begin n_bad++; $display("FAIL reset_we got=%b exp=0", imem_we); end
    n_cmp++; if (imem_addr !== '0)     begin n_bad++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    n_cmp++; if (imem_wdata !== '0)    begin n_bad++; $display("FAIL reset_wdata got=%0h exp=0", imem_wdata); end
    n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_reset_n got=%b exp=0", cpu_reset_n); end
    n_cmp++; if (byte_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_ready got=%b exp=0", byte_ready); end
    n_cmp++; if (done !== 1'b0)        begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (error !== 1'b0)       begin n_bad++; $display("FAIL reset_error got=%b exp=0", error); end
    n_cmp++; if (wr_q.size() != 0)     begin n_bad++; $display("FAIL idle_no_write got=%0d exp=0", wr_q.size()); end
  endtask

  task automatic test_single_good();
    logic [7:0] s[$];
    bit ok;
    s = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    pulse_start();
    n_cmp++; if (byte_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_after_start got=%b exp=1", byte_ready); end
    wr_q.delete();
    foreach (s[i]) begin
      send_byte(s[i], ok);
      if (i == 5) begin
        // Last word's strobe coincides with the first checksum cycle.
        n_cmp++; if (imem_we !== 1'b1 || byte_ready !== 1'b1)
          begin n_bad++; $display("FAIL single_we_in_csum got we=%b rdy=%b exp 1 1", imem_we, byte_ready); end
      end
    end
    n_cmp++; if (done !== 1'b1 || cpu_reset_n !== 1'b1 || error !== 1'b0)
      begin n_bad++; $display("FAIL single_run got done=%b crn=%b err=%b exp 1 1 0", done, cpu_reset_n, error); end
    n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL single_wr_count got=%0d exp=1", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0].addr != 0 || wr_q[0].data !== 32'h20080005)
        begin n_bad++; $display("FAIL single_wr got=%0d:%08h exp=0:20080005", wr_q[0].addr, wr_q[0].data); end
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] s[$];
    int sent;
    s = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    pulse_start();
    n_cmp++; if (cpu_reset_n !== 1'b0 || done !== 1'b0)
      begin n_bad++; $display("FAIL bad_start_from_run got crn=%b done=%b exp 0 0", cpu_reset_n, done); end
    wr_q.delete();
    send_stream(s, 0, sent);
    n_cmp++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset_n !== 1'b0)
      begin n_bad++; $display("FAIL bad_csum_err got err=%b done=%b crn=%b exp 1 0 0", error, done, cpu_reset_n); end
    n_cmp++; if (wr_q.size() != 1 || wr_q[0].data !== 32'h20080005)
      begin n_bad++; $display("FAIL bad_csum_word_kept got count=%0d exp=1 word 20080005", wr_q.size()); end
  endtask

  task automatic test_len_limits();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    int          sent;
    // N=0 and N=DEPTH+1 are rejected right after the low length byte.
    for (int t = 0; t < 2; t++) begin
      s = (t == 0) ? '{8'h00, 8'h00} : '{8'h01, 8'h01};
      pulse_start();
      wr_q.delete();
      send_stream(s, 0, sent);
      n_cmp++; if (error !== 1'b1 || byte_ready !== 1'b0)
        begin n_bad++; $display("FAIL len_reject_%0d got err=%b rdy=%b exp 1 0", t, error, byte_ready); end
      repeat (4) @(negedge clk);
      n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL len_reject_nowrite_%0d got=%0d exp=0", t, wr_q.size()); end
    end
    // Full-depth image with an incrementing byte pattern.
    w = {};
    for (int i = 0; i < DEPTH; i++)
      w.push_back({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    build_stream(w, 1'b0, s);
    pulse_start();
    wr_q.delete();
    send_stream(s, 0, sent);
    n_cmp++; if (sent != s.size()) begin n_bad++; $display("FAIL full_accepted got=%0d exp=%0d", sent, s.size()); end
    n_cmp++; if (done !== 1'b1 || cpu_reset_n !== 1'b1)
      begin n_bad++; $display("FAIL full_run got done=%b crn=%b exp 1 1", done, cpu_reset_n); end
    n_cmp++; if (wr_q.size() != DEPTH) begin n_bad++; $display("FAIL full_wr_count got=%0d exp=%0d", wr_q.size(), DEPTH); end
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++; if (wr_q[i].addr != i || wr_q[i].data !== w[i])
          begin n_bad++; $display("FAIL full_wr_%0d got=%0d:%08h exp=%0d:%08h", i, wr_q[i].addr, wr_q[i].data, i, w[i]); end
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    int          sent;
    for (int rep = 0; rep < 3; rep++) begin
      w = {$urandom, $urandom, $urandom};
      build_stream(w, 1'b0, s);
      pulse_start();
      wr_q.delete();
      send_stream(s, 5, sent);
      n_cmp++; if (done !== 1'b1 || error !== 1'b0)
        begin n_bad++; $display("FAIL gaps_run_%0d got done=%b err=%b exp 1 0", rep, done, error); end
      n_cmp++; if (wr_q.size() != 3) begin n_bad++; $display("FAIL gaps_count_%0d got=%0d exp=3", rep, wr_q.size()); end
      else begin
        for (int i = 0; i < 3; i++) begin
          n_cmp++; if (wr_q[i].addr != i || wr_q[i].data !== w[i])
            begin n_bad++; $display("FAIL gaps_wr_%0d_%0d got=%0d:%08h exp=%0d:%08h", rep, i, wr_q[i].addr, wr_q[i].data, i, w[i]); end
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    bit          ok;
    w = {$urandom, $urandom, $urandom};
    build_stream(w, 1'b0, s);
    pulse_start();
    wr_q.delete();
    for (int i = 0; i < 8; i++) send_byte(s[i], ok);   // header, word 0, half of word 1
    repeat (TIMEOUT - 1) @(negedge clk);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL timeout_early got err=%b exp=0 after %0d idle", error, TIMEOUT-1); end
    @(negedge clk);
    n_cmp++; if (error !== 1'b1 || cpu_reset_n !== 1'b0)
      begin n_bad++; $display("FAIL timeout_err got err=%b crn=%b exp 1 0", error, cpu_reset_n); end
    n_cmp++; if (wr_q.size() != 1 || wr_q[0].data !== w[0])
      begin n_bad++; $display("FAIL timeout_writes got count=%0d exp=1", wr_q.size()); end
  endtask

  task automatic test_reload();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    int          sent;
    w = {32'hDEADBEEF};
    build_stream(w, 1'b0, s);
    pulse_start();
    send_stream(s, 0, sent);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL reload_first got done=%b exp=1", done); end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    n_cmp++; if (cpu_reset_n !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b1)
      begin n_bad++; $display("FAIL reload_drop got crn=%b done=%b rdy=%b exp 0 0 1", cpu_reset_n, done, byte_ready); end
    w = {$urandom, $urandom};
    build_stream(w, 1'b0, s);
    wr_q.delete();
    send_stream(s, 0, sent);
    n_cmp++; if (done !== 1'b1 || cpu_reset_n !== 1'b1)
      begin n_bad++; $display("FAIL reload_run got done=%b crn=%b exp 1 1", done, cpu_reset_n); end
    n_cmp++; if (wr_q.size() != 2 || wr_q[0].addr != 0 || wr_q[0].data !== w[0] ||
                 wr_q[1].addr != 1 || wr_q[1].data !== w[1])
      begin n_bad++; $display("FAIL reload_writes got count=%0d exp=2 at 0..1", wr_q.size()); end
  endtask

  task automatic test_midreset();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    bit          ok;
    int          sent;
    w = {$urandom | 32'h1, $urandom};
    build_stream(w, 1'b0, s);
    pulse_start();
    wr_q.delete();
    for (int i = 0; i < 8; i++) send_byte(s[i], ok);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++; if ({imem_we, imem_addr, imem_wdata, cpu_reset_n, byte_ready, done, error} !== '0)
      begin n_bad++; $display("FAIL midreset_outputs got we=%b addr=%0h wd=%08h crn=%b rdy=%b done=%b err=%b exp all 0",
                              imem_we, imem_addr, imem_wdata, cpu_reset_n, byte_ready, done, error); end
    byte_valid = 1'b1; byte_data = 8'h5A;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    n_cmp++; if (byte_ready !== 1'b0 || error !== 1'b0)
      begin n_bad++; $display("FAIL midreset_idle got rdy=%b err=%b exp 0 0", byte_ready, error); end
    n_cmp++; if (wr_q.size() != 1 || wr_q[0].data !== w[0])
      begin n_bad++; $display("FAIL midreset_partial got count=%0d exp=1", wr_q.size()); end
    // From IDLE a fresh session still loads.
    w = {32'h0BADF00D};
    build_stream(w, 1'b0, s);
    pulse_start();
    wr_q.delete();
    send_stream(s, 0, sent);
    n_cmp++; if (done !== 1'b1 || wr_q.size() != 1 || wr_q[0].data !== 32'h0BADF00D)
      begin n_bad++; $display("FAIL midreset_reload got done=%b count=%0d exp 1 1", done, wr_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_good();
    test_bad_csum();
    test_len_limits();
    test_gaps();
    test_timeout();
    test_reload();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The core's fetch path only reads that memory; this block fills it at boot from a byte stream.
- While loading, it holds the core in reset via cpu_reset_n. It releases the core only after a complete, checksum-verified image has been written.
- Sits between an external byte source (UART RX or test bench) and the instruction memory write port.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory; matches fetch index pc[9:2].
- DEPTH, 256, number of 32-bit words in the memory; must be ≤ 2**ADDR_W.
- TIMEOUT, 1000000, maximum clk cycles allowed between accepted bytes inside a session; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- load_start  input  1  single-cycle pulse that begins a load session.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte; a handshake occurs when byte_valid and byte_ready are both high.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_reset_n  output  1  reset to the core; active-low, registered.
- done  output  1  level; high in RUN.
- error  output  1  level; high in ERR.

Behaviour:
- Reset values: state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, byte_ready=0, done=0, error=0. The checksum accumulator, byte counter, word counter and timeout counter all clear to 0.
- Stream format:
  - LEN_HI byte, then LEN_LO byte: word count N, big-endian, 16 bits.
  - 4*N data bytes: each word big-endian, first byte goes to [31:24]; words are written to consecutive addresses starting at 0.
  - One checksum byte: XOR of every preceding byte in the session, header bytes included.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR.
- byte_ready is 1 only in LEN_HI, LEN_LO, DATA and CSUM.
- cpu_reset_n is 1 only in RUN.
- Transitions:
  - load_start in IDLE, RUN or ERR → LEN_HI. On that edge, clear the accumulators and address and deassert done/error; cpu_reset_n returns to 0 on the same edge.
  - load_start is ignored in LEN_HI, LEN_LO, DATA and CSUM.
  - LEN_HI handshake → LEN_LO.
  - LEN_LO handshake → DATA, unless N==0 or N>DEPTH, in which case → ERR.
  - DATA: a 2-bit byte counter shifts bytes into the word register. On the 4th byte's handshake edge, register imem_wdata and imem_addr; imem_we=1 for exactly the following cycle. The address increments after the write.
  - DATA → CSUM on the 4th byte of word N-1. The last word's write strobe coincides with the first CSUM cycle.
  - CSUM handshake: byte equal to the accumulator → RUN; otherwise → ERR.
- Write address never wraps: N≤DEPTH is guaranteed by the length check.
- Timeout: in LEN_HI through CSUM, the counter increments every cycle without a handshake and clears on each handshake. Reaching TIMEOUT → ERR.
- ERR: the core stays in reset. Words already written stay in memory; no rollback.
- Throughput: one byte per cycle sustained. There are no back-pressure bubbles around writes.
- reset_n low mid-session: abort immediately to reset values. The partially written image is left in memory.
- byte_valid outside the accepting states: ignored, no handshake.

Decomposition:
- Shared package mips_loader_pkg holds:
  - the state encoding constants;
  - HDR_BYTES=2 and BYTES_PER_WORD=4;
  - the default ADDR_W/DEPTH values shared with InstructionMem sizing.
- One sub-module, word_packer:
  - owns the byte counter, the big-endian shift register and the registered word_valid pulse;
  - imem_loader owns the FSM, the length/checksum/timeout logic and the address counter.

Test Plan:
- Single word, good checksum: reset, then load_start. Send 00 01 20 08 00 05 2C, one byte per cycle.
  - Required: exactly one imem_we, with addr 0 and wdata 0x20080005.
  - done=1 and cpu_reset_n=1 on the cycle after the 2C handshake.
- Bad checksum: same stream ending in 2D instead of 2C.
  - Required: the word is still written; error=1, done=0, cpu_reset_n stays 0.
- Length limits:
  - N=0 (00 00) → ERR after LEN_LO, with no writes.
  - N=257 with DEPTH=256 (01 01) → ERR after LEN_LO, with no writes.
  - N=256 with an incrementing pattern → 256 writes at addr 0..255, then RUN.
- Back-pressure gaps and timeout, with TIMEOUT=16:
  - Random 0–5 cycle gaps between bytes of a 3-word image → the correct three words are written and the session succeeds.
  - A 16-cycle gap mid-DATA → error=1.
- Reload from RUN: after a successful load, pulse load_start.
  - Required: cpu_reset_n drops to 0 on the next edge and done clears.
  - A second 2-word image overwrites addr 0–1 and the block returns to RUN.
- reset_n low for 1 cycle during DATA (after 2 bytes of word 1).
  - Required: all outputs return to reset values and the state is IDLE.
  - No imem_we for the partial word.
